// File: rtl/branch_predictor_if.sv
// Fetch/update bundle between the front end, the branch unit and the predictor.
// The predictor takes the slave modport; the pipeline side takes master.
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;
  logic                  update_en;
  logic [DATA_WIDTH-1:0] update_pc;
  logic                  update_taken;
  logic [DATA_WIDTH-1:0] update_target;
  logic                  update_pred_taken;
  logic [DATA_WIDTH-1:0] update_pred_target;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [31:0]           branch_count;
  logic [31:0]           mispredict_count;

  modport master (
    output fetch_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational prediction
// and mispredict detection, plus branch/mispredict statistics.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [31:0]           branch_count_q;
  logic [31:0]           mispredict_count_q;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]      f_tag, u_tag;
  logic                  f_hit, u_hit;
  logic                  pred_taken;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] fetch_next, update_next;

  assign f_idx = bus.fetch_pc[INDEX_BITS+1:2];
  assign f_tag = bus.fetch_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign u_idx = bus.update_pc[INDEX_BITS+1:2];
  assign u_tag = bus.update_pc[DATA_WIDTH-1:INDEX_BITS+2];

  assign fetch_next  = bus.fetch_pc + DATA_WIDTH'(4);
  assign update_next = bus.update_pc + DATA_WIDTH'(4);

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Gated by rst so outputs are clean even before the first reset edge.
  assign pred_taken = !rst && f_hit && ctr_q[f_idx][1];
  assign mispredict = !rst && bus.update_en &&
                      ((bus.update_taken != bus.update_pred_taken) ||
                       (bus.update_taken && (bus.update_target != bus.update_pred_target)));

  assign bus.pred_taken       = pred_taken;
  assign bus.pred_target      = pred_taken ? target_q[f_idx] : fetch_next;
  assign bus.mispredict       = mispredict;
  assign bus.redirect_pc      = (mispredict && bus.update_taken) ? bus.update_target
                                                                 : update_next;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bus.update_en) begin
      branch_count_q <= branch_count_q + 32'd1;
      if (mispredict) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
      if (u_hit) begin
        if (bus.update_taken) begin
          if (ctr_q[u_idx] != 2'b11) begin
            ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          end
          target_q[u_idx] <= bus.update_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (bus.update_taken) begin
        // Taken miss replaces whatever occupies the slot, starting weakly taken.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bus.update_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus pushes expectations,
// a negedge monitor drains and compares them.
module tb_branch_predictor;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.DATA_WIDTH(DW)) bus ();

  branch_predictor #(.DATA_WIDTH(DW), .INDEX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 prediction, 1 mispredict/redirect, 2 counters
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sbq[$];
  bit   chk = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t e;

  always @(negedge clk) begin
    if (chk) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_vec++;
        case (e.kind)
          0: if (bus.pred_taken !== e.a[0] || bus.pred_target !== e.b) begin
               n_bad++;
               $display("FAIL %s: pred_taken=%0b pred_target=%h, expected %0b %h",
                        e.name, bus.pred_taken, bus.pred_target, e.a[0], e.b);
             end
          1: if (bus.mispredict !== e.a[0] || bus.redirect_pc !== e.b) begin
               n_bad++;
               $display("FAIL %s: mispredict=%0b redirect_pc=%h, expected %0b %h",
                        e.name, bus.mispredict, bus.redirect_pc, e.a[0], e.b);
             end
          default: if (bus.branch_count !== e.a || bus.mispredict_count !== e.b) begin
               n_bad++;
               $display("FAIL %s: branch_count=%0d mispredict_count=%0d, expected %0d %0d",
                        e.name, bus.branch_count, bus.mispredict_count, e.a, e.b);
             end
        endcase
      end
    end
  end

  task automatic cyc(input logic r, input logic [31:0] fpc, input logic uen,
                     input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                     input logic upt, input logic [31:0] uptgt);
    @(posedge clk);
    #1;
    rst                    = r;
    bus.fetch_pc           = fpc;
    bus.update_en          = uen;
    bus.update_pc          = upc;
    bus.update_taken       = ut;
    bus.update_target      = utgt;
    bus.update_pred_taken  = upt;
    bus.update_pred_target = uptgt;
    chk                    = 1'b1;
  endtask

  task automatic ep(input string n, input logic pt, input logic [31:0] tgt);
    sbq.push_back('{n, 0, {31'd0, pt}, tgt});
  endtask

  task automatic em(input string n, input logic m, input logic [31:0] rpc);
    sbq.push_back('{n, 1, {31'd0, m}, rpc});
  endtask

  task automatic ec(input string n, input logic [31:0] bc, input logic [31:0] mc);
    sbq.push_back('{n, 2, bc, mc});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.fetch_pc = '0; bus.update_en = 1'b0; bus.update_pc = '0;
    bus.update_taken = 1'b0; bus.update_target = '0;
    bus.update_pred_taken = 1'b0; bus.update_pred_target = '0;

    // reset with a would-be update present
    cyc(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    ep("rst_pred", 0, 32'h44); em("rst_mis", 0, 32'h44);
    // update_en low must not flag even with mismatching fields
    cyc(0, 32'h40, 0, 32'h40, 1, 32'h100, 0, 32'h44);
    ep("post_rst_pred", 0, 32'h44); em("idle_mis", 0, 32'h44); ec("post_rst_cnt", 0, 0);
    // first taken update allocates; prediction this cycle is pre-update
    cyc(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    ep("alloc_same_cycle", 0, 32'h44); em("alloc_mis", 1, 32'h100); ec("alloc_cnt", 0, 0);
    cyc(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ep("alloc_pred", 1, 32'h100); ec("alloc_cnt_after", 1, 1);
    // three correctly predicted taken updates: ctr 10 -> 11 saturating
    cyc(0, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100);
    em("correct_mis", 0, 32'h44);
    cyc(0, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100);
    ec("correct_cnt", 2, 1);
    cyc(0, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100);
    // alias at index 0, tag 2, not-taken miss: no change
    cyc(0, 32'h40, 1, 32'h80, 0, 32'h0, 0, 32'h84);
    ep("sat_pred", 1, 32'h100); em("alias_nt_mis", 0, 32'h84);
    cyc(0, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100);
    ep("alias_nt_keep", 1, 32'h100); em("nt1_mis", 1, 32'h44); ec("nt1_cnt", 5, 1);
    cyc(0, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100);
    ep("ctr10_pred", 1, 32'h100); em("nt2_mis", 1, 32'h44); ec("nt2_cnt", 6, 2);
    cyc(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ep("ctr01_pred", 0, 32'h44); ec("nt_cnt_after", 7, 3);
    cyc(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    em("retake_mis", 1, 32'h100);
    // same-cycle hazard: old target visible now, new target next cycle
    cyc(0, 32'h40, 1, 32'h40, 1, 32'h300, 1, 32'h100);
    ep("hazard_old", 1, 32'h100); em("tgt_mis", 1, 32'h300); ec("hazard_cnt", 8, 4);
    cyc(0, 32'h40, 1, 32'h80, 1, 32'h200, 0, 32'h84);
    ep("hazard_new", 1, 32'h300); em("alias_t_mis", 1, 32'h200); ec("hazard_cnt2", 9, 5);
    cyc(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ep("alias_evict", 0, 32'h44); ec("evict_cnt", 10, 6);
    cyc(0, 32'h82, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ep("misaligned_hit", 1, 32'h200);
    cyc(0, 32'h82, 1, 32'h80, 1, 32'h200, 1, 32'h200);
    em("alias_correct_mis", 0, 32'h84); ec("alias_correct_cnt", 10, 6);
    cyc(0, 32'h82, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ec("mc_unchanged", 11, 6);
    // reset overrides a simultaneous update
    cyc(1, 32'h40, 1, 32'h40, 1, 32'h500, 0, 32'h44);
    ep("rst2_pred", 0, 32'h44); em("rst2_mis", 0, 32'h44);
    cyc(0, 32'h82, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ep("rst2_cleared", 0, 32'h86); ec("rst2_cnt", 0, 0);
    cyc(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ep("rst2_upd_ignored", 0, 32'h44); ec("rst2_cnt2", 0, 0);
    // fall-through wraps modulo 2^32
    cyc(0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
    ep("wrap_pred", 0, 32'h0); em("wrap_redirect", 0, 32'h0);

    @(posedge clk);
    #1;
    chk = 1'b0;
    bus.update_en = 1'b0;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage direction predictor and branch target buffer (BTB). It is the front end of the branch decision path.
- Fetch asks for a prediction for the current PC. The execute-stage branch unit later resolves the branch and returns the taken/not-taken outcome and target through the update port.
- The block flags mispredicts for pipeline flush and keeps branch and mispredict statistics.

Parameters:
- DATA_WIDTH, 32, PC/target width.
- INDEX_BITS, 4, log2 of table entries (16). Index = pc[INDEX_BITS+1:2]. Tag = pc[DATA_WIDTH-1:INDEX_BITS+2].

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- fetch_pc  input  DATA_WIDTH  PC being fetched this cycle.
- pred_taken  output  1  predicted taken for fetch_pc.
- pred_target  output  DATA_WIDTH  predicted next PC.
- update_en  input  1  a control-transfer instruction resolves this cycle.
- update_pc  input  DATA_WIDTH  PC of the resolving instruction.
- update_taken  input  1  resolved outcome; this is the branch unit's pc_sel.
- update_target  input  DATA_WIDTH  resolved target address.
- update_pred_taken  input  1  prediction that was made for update_pc, pipelined from fetch.
- update_pred_target  input  DATA_WIDTH  predicted next PC, pipelined from fetch.
- mispredict  output  1  resolved path differs from the predicted path; flush request.
- redirect_pc  output  DATA_WIDTH  correct next PC when mispredict=1.
- branch_count  output  32  number of resolved updates.
- mispredict_count  output  32  number of mispredicts.

Behaviour:
- Storage: 2^INDEX_BITS entries held in flops, not RAM. Each entry has valid (1), tag, target (DATA_WIDTH) and ctr (2-bit saturating counter).
- Reset: the whole table is cleared in one cycle. Every entry gets valid=0 and ctr=2'b01 (weakly not-taken); tag and target go to 0. branch_count and mispredict_count go to 0.
  - During and immediately after reset: pred_taken=0, pred_target=fetch_pc+4, mispredict=0.
  - rst overrides update_en in the same cycle.
- Prediction is combinational, with zero latency.
  - hit = valid[idx] && tag[idx]==fetch_tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = target[idx] if pred_taken, else fetch_pc+4, computed modulo 2^DATA_WIDTH.
- Mispredict is combinational and only asserted when update_en=1.
  - mispredict = (update_taken != update_pred_taken) || (update_taken && update_target != update_pred_target).
  - redirect_pc = update_target if update_taken, else update_pc+4.
  - When mispredict=0, redirect_pc is don't-care and is driven as update_pc+4.
- Table update happens on the clock edge when update_en=1 and rst=0. Let u = entry at update_pc's index.
  - Hit on u, taken: ctr increments, saturating at 2'b11; target := update_target.
  - Hit on u, not taken: ctr decrements, saturating at 2'b00; target unchanged.
  - Miss (invalid entry or tag mismatch), taken: allocate/replace the entry with valid=1, tag=update tag, target=update_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change. An existing entry with another tag is not disturbed.
- Counters:
  - branch_count increments on each update_en.
  - mispredict_count increments when mispredict=1.
  - Both wrap from 0xFFFF_FFFF to 0.
- Simultaneous read and write at the same index: the prediction uses the pre-update contents (no bypass). The new contents are visible from the next cycle.
- Misaligned PC bits [1:0] are ignored for index and tag.

Test Plan:
- Reset, then fetch_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044. Both counters read 0.
- Update pc=0x40, taken=1, target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle, fetch 0x40 gives pred_taken=1, pred_target=0x100. branch_count=1, mispredict_count=1.
- Saturation:
  - Three further taken updates on 0x40 leave ctr at 11.
  - One not-taken update -> ctr=10, still predicted taken.
  - A second not-taken update -> ctr=01, pred_taken=0, pred_target=0x44.
- Alias at index 0: pc 0x80 (tag 2) not-taken update on miss -> entry for 0x40 unchanged. A taken update for 0x80 with target 0x200 replaces it; fetch 0x40 then misses and gives pred_taken=0.
- Same-cycle hazard: fetch_pc=0x40 and a taken update on 0x40 (new target 0x300) in the same cycle -> this cycle shows the old target 0x100, the next cycle shows 0x300.
- Correct prediction: update with taken=1, target=0x100, pred_taken=1, pred_target=0x100 -> mispredict=0, and mispredict_count is unchanged. Asserting rst with update_en=1 -> the table is cleared and the update is ignored.
